// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter (writeback stage vs buffered long-unit results)
//
// Optional feature macro: WB_ARB_BYPASS_EN (long-unit result written in the same
// cycle when the FIFO is empty and the writeback stage does not need the port).
//
// Ports (wb_port_arbiter):
//   clk, reset                    core clock, synchronous active-high reset
//   ws_wb_valid/we/dest/data/pc   writeback stage write request
//   ws_wb_ready                   writeback stage may retire this cycle
//   lu_valid/dest/data/pc         long-unit result offer
//   lu_ready                      result FIFO accepts the offer this cycle
//   rf_we/waddr/wdata             register-file write port
//   debug_wb_*                    trace of every granted write
//
// Ports (wb_lu_fifo):
//   clk, reset                    core clock, synchronous active-high reset
//   push, push_data               enqueue at posedge
//   pop                           drop the head entry at posedge
//   head_data, empty, full        head entry and occupancy flags

module wb_lu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
endmodule

module wb_port_arbiter #(
  parameter int LU_FIFO_DEPTH = 2,
  parameter int MAX_WAIT      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_wb_valid,
  input  logic        ws_wb_we,
  input  logic [4:0]  ws_wb_dest,
  input  logic [31:0] ws_wb_data,
  input  logic [31:0] ws_wb_pc,
  output logic        ws_wb_ready,
  input  logic        lu_valid,
  input  logic [4:0]  lu_dest,
  input  logic [31:0] lu_data,
  input  logic [31:0] lu_pc,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);
  localparam int EW     = 5 + 32 + 32;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  typedef enum logic [0:0] {
    PIPE_PRI = 1'b0,
    LU_FORCE = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;

  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic [EW-1:0] head;
  logic [4:0]    head_dest;
  logic [31:0]   head_data;
  logic [31:0]   head_pc;

  logic pipe_req;
  logic lu_req;
  logic bypass_ok;
  logic grant_pipe;
  logic grant_lu;
  logic grant_byp;

  logic        win_any;
  logic [4:0]  win_dest;
  logic [31:0] win_data;
  logic [31:0] win_pc;

  assign pipe_req = ws_wb_valid & ws_wb_we;
  assign lu_req   = ~fifo_empty;
  assign {head_dest, head_data, head_pc} = head;

`ifdef WB_ARB_BYPASS_EN
  // Only reachable from PIPE_PRI with an empty FIFO; the state check lives in the FSM.
  assign bypass_ok = lu_valid & fifo_empty & ~pipe_req;
`else
  assign bypass_ok = 1'b0;
`endif

  // A full FIFO never takes a new entry, even when its head pops this cycle.
  assign lu_ready  = reset | ~fifo_full;
  assign fifo_push = lu_valid & ~fifo_full & ~reset & ~grant_byp;

  wb_lu_fifo #(
    .DEPTH (LU_FIFO_DEPTH),
    .WIDTH (EW)
  ) u_lu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({lu_dest, lu_data, lu_pc}),
    .pop       (grant_lu),
    .head_data (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PIPE_PRI;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_nx     = wait_cnt;
    grant_pipe  = 1'b0;
    grant_lu    = 1'b0;
    grant_byp   = 1'b0;
    ws_wb_ready = 1'b1;
    case (state)
      PIPE_PRI: begin
        if (pipe_req)       grant_pipe = 1'b1;
        else if (lu_req)    grant_lu   = 1'b1;
        else if (bypass_ok) grant_byp  = 1'b1;
        // Count cycles in which a waiting head entry loses to the pipe.
        if (grant_lu) begin
          wait_nx = '0;
        end else if (lu_req) begin
          wait_nx = wait_cnt + 1'b1;
          if (wait_nx == MAX_WAIT_C) state_nx = LU_FORCE;
        end
      end
      LU_FORCE: begin
        // Exactly one long-unit write, holding off a writing WB instruction.
        grant_lu    = lu_req;
        ws_wb_ready = ~pipe_req;
        if (lu_req) begin
          state_nx = PIPE_PRI;
          wait_nx  = '0;
        end
      end
      default: state_nx = PIPE_PRI;
    endcase
    if (reset) begin
      grant_pipe  = 1'b0;
      grant_lu    = 1'b0;
      grant_byp   = 1'b0;
      ws_wb_ready = 1'b1;
    end
  end

  always_comb begin
    win_any  = 1'b0;
    win_dest = '0;
    win_data = '0;
    win_pc   = '0;
    if (grant_pipe) begin
      win_any  = 1'b1;
      win_dest = ws_wb_dest;
      win_data = ws_wb_data;
      win_pc   = ws_wb_pc;
    end else if (grant_lu) begin
      win_any  = 1'b1;
      win_dest = head_dest;
      win_data = head_data;
      win_pc   = head_pc;
    end else if (grant_byp) begin
      win_any  = 1'b1;
      win_dest = lu_dest;
      win_data = lu_data;
      win_pc   = lu_pc;
    end
  end

  // r0 writes still win the port and are consumed, but never reach the RF.
  assign rf_we             = win_any & (win_dest != 5'd0);
  assign rf_waddr          = win_dest;
  assign rf_wdata          = win_data;
  assign debug_wb_pc       = win_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = win_dest;
  assign debug_wb_rf_wdata = win_data;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - bench for wb_port_arbiter

module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int MAXW  = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic ws_wb_valid, ws_wb_we;
  logic [4:0] ws_wb_dest;
  logic [31:0] ws_wb_data, ws_wb_pc;
  logic ws_wb_ready;
  logic lu_valid;
  logic [4:0] lu_dest;
  logic [31:0] lu_data, lu_pc;
  logic lu_ready;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, debug_wb_pc;
  logic [3:0] debug_wb_rf_we;
  logic [4:0] debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.LU_FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .ws_wb_valid(ws_wb_valid), .ws_wb_we(ws_wb_we), .ws_wb_dest(ws_wb_dest),
    .ws_wb_data(ws_wb_data), .ws_wb_pc(ws_wb_pc), .ws_wb_ready(ws_wb_ready),
    .lu_valid(lu_valid), .lu_dest(lu_dest), .lu_data(lu_data), .lu_pc(lu_pc),
    .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // Reference model: a queue of waiting results, a count of lost cycles for the
  // oldest one, and a flag saying the oldest one is owed the next write.
  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   losses = 0;
  bit   owed = 1'b0;

  bit          e_head, e_byp, e_grant, e_we, e_ws_ready, e_lu_ready;
  logic [4:0]  e_dest;
  logic [31:0] e_data, e_pc;

  task automatic model_comb();
    bit preq;
    preq = ws_wb_valid && ws_wb_we;
    e_head = 0; e_byp = 0; e_grant = 0; e_we = 0;
    e_dest = '0; e_data = '0; e_pc = '0;
    e_ws_ready = 1'b1;
    e_lu_ready = (mq.size() < DEPTH);
    if (reset) begin
      e_lu_ready = 1'b1;
      return;
    end
    if (owed) begin
      e_head = 1'b1;
      e_ws_ready = !preq;
    end else if (preq) begin
      e_grant = 1'b1;
      e_dest = ws_wb_dest; e_data = ws_wb_data; e_pc = ws_wb_pc;
    end else if (mq.size() > 0) begin
      e_head = 1'b1;
    end else if (BYP && lu_valid) begin
      e_byp = 1'b1;
      e_grant = 1'b1;
      e_dest = lu_dest; e_data = lu_data; e_pc = lu_pc;
    end
    if (e_head) begin
      e_grant = 1'b1;
      e_dest = mq[0].dest; e_data = mq[0].data; e_pc = mq[0].pc;
    end
    e_we = e_grant && (e_dest != 5'd0);
  endtask

  task automatic model_clock();
    bit had;
    bit accept;
    ent_t ne;
    model_comb();
    if (reset) begin
      mq.delete();
      losses = 0;
      owed = 1'b0;
      return;
    end
    had = (mq.size() > 0);
    accept = lu_valid && e_lu_ready && !e_byp;
    if (e_head) begin
      mq.delete(0);
      losses = 0;
      owed = 1'b0;
    end else if (had) begin
      losses++;
      if (losses == MAXW) owed = 1'b1;
    end
    if (accept) begin
      ne.dest = lu_dest; ne.data = lu_data; ne.pc = lu_pc;
      mq.push_back(ne);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive_idle();
    ws_wb_valid = 0; ws_wb_we = 0; ws_wb_dest = '0; ws_wb_data = '0; ws_wb_pc = '0;
    lu_valid = 0; lu_dest = '0; lu_data = '0; lu_pc = '0;
  endtask

  task automatic drive_ws(input logic [4:0] d, input logic [31:0] v);
    ws_wb_valid = 1; ws_wb_we = 1; ws_wb_dest = d; ws_wb_data = v; ws_wb_pc = 32'h1000 + {27'd0, d};
  endtask

  task automatic drive_lu(input logic [4:0] d, input logic [31:0] v);
    lu_valid = 1; lu_dest = d; lu_data = v; lu_pc = 32'h8000 + {27'd0, d};
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) drive_ws(5'd5, 32'h1234);
      @(negedge clk);
      checks++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we cyc%0d: got %b want 0", c, rf_we); else passes++;
      checks++; if (lu_ready !== 1'b1) $display("FAIL reset_lu_ready cyc%0d: got %b want 1", c, lu_ready); else passes++;
      checks++; if (ws_wb_ready !== 1'b1) $display("FAIL reset_ws_ready cyc%0d: got %b want 1", c, ws_wb_ready); else passes++;
      tick();
    end
    reset = 0;
    drive_ws(5'd5, 32'h1234);
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234})
      $display("FAIL pipe_write: got we=%b a=%0d d=%h want we=1 a=5 d=1234", rf_we, rf_waddr, rf_wdata); else passes++;
    checks++; if ({debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_pc} !== {4'hf, 5'd5, 32'h1234, 32'h1005})
      $display("FAIL pipe_debug: got we=%h n=%0d d=%h pc=%h want f/5/1234/1005",
               debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_pc); else passes++;
    checks++; if (ws_wb_ready !== 1'b1) $display("FAIL pipe_ws_ready: got %b want 1", ws_wb_ready); else passes++;
    tick();
    drive_idle();
  endtask

  task automatic test_lu_latency();
    do_reset();
    drive_lu(5'd7, 32'hA);
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr} !== (BYP ? {1'b1, 5'd7} : {1'b0, 5'd0}))
      $display("FAIL lu_cycle0: got we=%b a=%0d want we=%b", rf_we, rf_waddr, BYP); else passes++;
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== (BYP ? {1'b0, 5'd0, 32'h0} : {1'b1, 5'd7, 32'hA}))
      $display("FAIL lu_cycle1: got we=%b a=%0d d=%h", rf_we, rf_waddr, rf_wdata); else passes++;
    tick();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) $display("FAIL lu_drained: got %b want 0", rf_we); else passes++;
  endtask

  task automatic test_starvation();
    do_reset();
    drive_ws(5'd1, 32'h100);
    drive_lu(5'd9, 32'h99);
    tick();
    lu_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      drive_ws(5'(c + 10), 32'h200 + c);
      @(negedge clk);
      if (c == 5) begin
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99})
          $display("FAIL starve_force_write: got we=%b a=%0d d=%h want 1/9/99", rf_we, rf_waddr, rf_wdata); else passes++;
        checks++; if (ws_wb_ready !== 1'b0) $display("FAIL starve_ws_stall: got %b want 0", ws_wb_ready); else passes++;
        tick();
      end else begin
        checks++; if ({rf_we, rf_waddr, ws_wb_ready} !== {1'b1, 5'(c + 10), 1'b1})
          $display("FAIL starve_pipe_cyc%0d: got we=%b a=%0d rdy=%b want 1/%0d/1", c, rf_we, rf_waddr, ws_wb_ready, c + 10);
        else passes++;
        tick();
      end
    end
    drive_idle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    drive_ws(5'd10, 32'h10); drive_lu(5'd3, 32'h33);
    tick();
    drive_ws(5'd11, 32'h11); drive_lu(5'd4, 32'h44);
    @(negedge clk);
    checks++; if (lu_ready !== 1'b1) $display("FAIL full_ready_c1: got %b want 1", lu_ready); else passes++;
    tick();
    drive_ws(5'd12, 32'h12); drive_lu(5'd6, 32'h66);
    @(negedge clk);
    checks++; if (lu_ready !== 1'b0) $display("FAIL full_ready_c2: got %b want 0", lu_ready); else passes++;
    tick();
    ws_wb_valid = 0; ws_wb_we = 0;
    @(negedge clk);
    checks++; if ({lu_ready, rf_we, rf_waddr} !== {1'b0, 1'b1, 5'd3})
      $display("FAIL full_pop_c3: got rdy=%b we=%b a=%0d want 0/1/3", lu_ready, rf_we, rf_waddr); else passes++;
    tick();
    @(negedge clk);
    checks++; if ({lu_ready, rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd4})
      $display("FAIL full_after_pop_c4: got rdy=%b we=%b a=%0d want 1/1/4", lu_ready, rf_we, rf_waddr); else passes++;
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h66})
      $display("FAIL full_held_c5: got we=%b a=%0d d=%h want 1/6/66", rf_we, rf_waddr, rf_wdata); else passes++;
    tick();
  endtask

  task automatic test_r0();
    do_reset();
    drive_ws(5'd0, 32'hDEAD); drive_lu(5'd0, 32'h55);
    @(negedge clk);
    checks++; if ({ws_wb_ready, rf_we} !== 2'b10) $display("FAIL r0_pipe: got rdy=%b we=%b want 1/0", ws_wb_ready, rf_we); else passes++;
    tick();
    ws_wb_valid = 0; ws_wb_we = 0;
    drive_lu(5'd8, 32'h88);
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) $display("FAIL r0_lu: got we=%b want 0", rf_we); else passes++;
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h88})
      $display("FAIL r0_popped: got we=%b a=%0d d=%h want 1/8/88", rf_we, rf_waddr, rf_wdata); else passes++;
    tick();
  endtask

  task automatic test_reset_in_force();
    do_reset();
    drive_ws(5'd1, 32'h1); drive_lu(5'd20, 32'h20);
    tick();
    drive_ws(5'd2, 32'h2); drive_lu(5'd21, 32'h21);
    tick();
    lu_valid = 0;
    for (int c = 3; c <= 5; c++) begin
      drive_ws(5'(c), 32'(c));
      tick();
    end
    drive_ws(5'd6, 32'h6);
    @(negedge clk);
    checks++; if ({ws_wb_ready, rf_we, rf_waddr, lu_ready} !== {1'b0, 1'b1, 5'd20, 1'b0})
      $display("FAIL force_entered: got rdy=%b we=%b a=%0d lrdy=%b want 0/1/20/0", ws_wb_ready, rf_we, rf_waddr, lu_ready);
    else passes++;
    reset = 1;
    #1;
    checks++; if ({rf_we, ws_wb_ready, lu_ready} !== 3'b011)
      $display("FAIL force_reset_outputs: got we=%b rdy=%b lrdy=%b want 0/1/1", rf_we, ws_wb_ready, lu_ready); else passes++;
    tick();
    reset = 0;
    drive_idle();
    @(negedge clk);
    checks++; if ({rf_we, lu_ready} !== 2'b01) $display("FAIL force_discard: got we=%b lrdy=%b want 0/1", rf_we, lu_ready); else passes++;
    tick();
    drive_ws(5'd7, 32'h7);
    @(negedge clk);
    checks++; if ({ws_wb_ready, rf_we, rf_waddr} !== {1'b1, 1'b1, 5'd7})
      $display("FAIL force_back_to_pipe: got rdy=%b we=%b a=%0d want 1/1/7", ws_wb_ready, rf_we, rf_waddr); else passes++;
    tick();
    drive_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      ws_wb_valid = ($urandom_range(0, 99) < 75);
      ws_wb_we = ($urandom_range(0, 99) < 85);
      ws_wb_dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ws_wb_data = $urandom;
      ws_wb_pc = $urandom;
      lu_valid = ($urandom_range(0, 99) < 40);
      lu_dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      lu_data = $urandom;
      lu_pc = $urandom;
      @(negedge clk);
      model_comb();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, ws_wb_ready, lu_ready}
          !== {e_we, e_dest, e_data, e_pc, {4{e_we}}, e_dest, e_data, e_ws_ready, e_lu_ready})
        $display("FAIL random_cyc%0d: got we=%b a=%0d d=%h pc=%h dwe=%h rdy=%b lrdy=%b want we=%b a=%0d d=%h pc=%h rdy=%b lrdy=%b",
                 c, rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_we, ws_wb_ready, lu_ready,
                 e_we, e_dest, e_data, e_pc, e_ws_ready, e_lu_ready);
      else passes++;
      tick();
    end
    reset = 0;
    drive_idle();
  endtask

  initial begin
    reset = 1;
    drive_idle();
    test_reset();
    test_lu_latency();
    test_starvation();
    test_fifo_full();
    test_r0();
    test_reset_in_force();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
